// File: rtl/tmds_encoder.sv
// TMDS 8b/10b channel encoder: three-register pipeline feeding a 10:1 serializer.
// Transition minimisation in S2, DC balancing against a 5-bit running disparity in S3.
module tmds_encoder (
    input  logic       clkin,
    input  logic       rstin,
    input  logic [7:0] din,
    input  logic       c0,
    input  logic       c1,
    input  logic       de,
    output logic [9:0] dout
);

    localparam logic [9:0] CTL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTL_TOKEN_11 = 10'b1010101011;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 0; i < 8; i++) begin
            s = s + {3'b000, v[i]};
        end
        return s;
    endfunction

    // S1: input capture
    logic [7:0] din_s1;
    logic       c0_s1;
    logic       c1_s1;
    logic       de_s1;
    logic [3:0] n1d;

    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            din_s1 <= 8'd0;
            c0_s1  <= 1'b0;
            c1_s1  <= 1'b0;
            de_s1  <= 1'b0;
            n1d    <= 4'd0;
        end else begin
            din_s1 <= din;
            c0_s1  <= c0;
            c1_s1  <= c1;
            de_s1  <= de;
            n1d    <= popcount8(din);
        end
    end

    // S2: transition minimisation
    logic       xnor_mode;
    logic [8:0] q_m_next;

    always_comb begin
        xnor_mode   = (n1d > 4'd4) || ((n1d == 4'd4) && !din_s1[0]);
        q_m_next    = 9'd0;
        q_m_next[0] = din_s1[0];
        for (int i = 1; i < 8; i++) begin
            q_m_next[i] = xnor_mode ? ~(q_m_next[i-1] ^ din_s1[i])
                                    :  (q_m_next[i-1] ^ din_s1[i]);
        end
        q_m_next[8] = ~xnor_mode;
    end

    logic [8:0] q_m;
    logic [3:0] n1q;
    logic [3:0] n0q;
    logic       de_s2;
    logic [1:0] ctl_s2;

    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            q_m    <= 9'd0;
            n1q    <= 4'd0;
            n0q    <= 4'd0;
            de_s2  <= 1'b0;
            ctl_s2 <= 2'b00;
        end else begin
            q_m    <= q_m_next;
            n1q    <= popcount8(q_m_next[7:0]);
            n0q    <= 4'd8 - popcount8(q_m_next[7:0]);
            de_s2  <= de_s1;
            ctl_s2 <= {c1_s1, c0_s1};
        end
    end

    // S3: DC balance; cnt is two's complement, all sums wrap at 5 bits
    logic [4:0] cnt;
    logic [4:0] cnt_next;
    logic [9:0] dout_next;
    logic [4:0] n1q_x;
    logic [4:0] n0q_x;
    logic [4:0] two_qm8;
    logic [4:0] two_nqm8;
    logic       cnt_zero;
    logic       cnt_pos;
    logic       cnt_neg;
    logic       balanced;
    logic       invert;

    always_comb begin
        n1q_x     = {1'b0, n1q};
        n0q_x     = {1'b0, n0q};
        two_qm8   = {3'b000,  q_m[8], 1'b0};
        two_nqm8  = {3'b000, ~q_m[8], 1'b0};
        cnt_zero  = (cnt == 5'd0);
        cnt_neg   = cnt[4];
        cnt_pos   = !cnt[4] && !cnt_zero;
        balanced  = cnt_zero || (n1q == n0q);
        invert    = (cnt_pos && (n1q > n0q)) || (cnt_neg && (n0q > n1q));
        dout_next = CTL_TOKEN_00;
        cnt_next  = 5'd0;

        if (de_s2) begin
            if (balanced) begin
                dout_next = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
                cnt_next  = q_m[8] ? (cnt + (n1q_x - n0q_x))
                                   : (cnt + (n0q_x - n1q_x));
            end else if (invert) begin
                dout_next = {1'b1, q_m[8], ~q_m[7:0]};
                cnt_next  = cnt + two_qm8 + (n0q_x - n1q_x);
            end else begin
                dout_next = {1'b0, q_m[8], q_m[7:0]};
                cnt_next  = cnt + (n1q_x - n0q_x) - two_nqm8;
            end
        end else begin
            case (ctl_s2)
                2'b00:   dout_next = CTL_TOKEN_00;
                2'b01:   dout_next = CTL_TOKEN_01;
                2'b10:   dout_next = CTL_TOKEN_10;
                default: dout_next = CTL_TOKEN_11;
            endcase
        end
    end

    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            dout <= 10'd0;
            cnt  <= 5'd0;
        end else begin
            dout <= dout_next;
            cnt  <= cnt_next;
        end
    end

endmodule
